// File: rtl/stopwatch_pkg.sv
// Shared types and default rates for the stopwatch controller and its datapath.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      SPLIT = 2'd3
   } sw_state_t;

   typedef logic [15:0] bcd4_t;

   localparam int unsigned DEF_IN_CLK_HZ = 50_000_000;
   localparam int unsigned DEF_TICK_HZ   = 100;

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Divides the system clock down to the datapath tick period. The counter only
// advances while enabled, so a paused stopwatch keeps its partial period.
// tick flags the cycle in which the counter sits at DIV-1 and is enabled,
// i.e. the cycle whose closing edge wraps the counter; the parent registers it.
module tick_prescaler #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   assign tick = en && (r_cnt == LAST);

   // Period counter: clear wins, otherwise count 0..DIV-1 while enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: turns debounced key pulses into the
// datapath tick enable and clear strobe, runs the run/pause/split FSM and
// owns the frozen-display hold register. All outputs are registered.
// Key handshake: each *_pulse is a one-cycle event sampled on the rising
// edge; there is no back-pressure, and an event that is not valid in the
// current state (or loses priority clr > start > lap) is dropped.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned IN_CLK_HZ = DEF_IN_CLK_HZ,
   parameter int unsigned TICK_HZ   = DEF_TICK_HZ
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_pulse,
   input  logic        lap_pulse,
   input  logic        clr_pulse,
   input  logic [15:0] cnt_digits,
   input  logic        cnt_max,
   output logic        tick,
   output logic        cnt_clear,
   output logic [15:0] disp,
   output logic [1:0]  state,
   output logic        lap_active
);

   localparam int unsigned DIV = IN_CLK_HZ / TICK_HZ;

   sw_state_t r_state;
   sw_state_t w_next;
   logic      w_en;
   logic      w_wrap;
   logic      w_sat;
   logic      w_clr;
   logic      w_latch;
   logic      r_tick;
   logic      r_clear;
   logic      r_lap;
   bcd4_t     r_hold;
   bcd4_t     r_disp;

   // Counting happens in RUN and SPLIT only.
   assign w_en = (r_state == RUN) || (r_state == SPLIT);

   // A period boundary reached while the datapath is already at its terminal
   // value stops the watch instead of letting the digits wrap.
   assign w_sat = w_wrap && cnt_max;

   tick_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_en),
      .clr   (w_clr),
      .tick  (w_wrap)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state, clear and latch decode; one event per cycle, clr > start > lap.
   always_comb begin
      w_next  = r_state;
      w_clr   = 1'b0;
      w_latch = 1'b0;
      case (r_state)
         IDLE: begin
            if (clr_pulse) begin
               w_clr = 1'b1;
            end else if (start_pulse) begin
               w_next = RUN;
            end
         end
         RUN: begin
            if (w_sat || start_pulse) begin
               w_next = PAUSE;
            end else if (lap_pulse) begin
               w_next  = SPLIT;
               w_latch = 1'b1;
            end
         end
         SPLIT: begin
            if (w_sat || start_pulse) begin
               w_next = PAUSE;
            end else if (lap_pulse) begin
               w_next = RUN;
            end
         end
         PAUSE: begin
            if (clr_pulse) begin
               w_next = IDLE;
               w_clr  = 1'b1;
            end else if (start_pulse) begin
               w_next = RUN;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Registered outputs: tick, clear strobe, hold register and display mux.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick  <= 1'b0;
         r_clear <= 1'b0;
         r_lap   <= 1'b0;
         r_hold  <= '0;
         r_disp  <= '0;
      end else begin
         r_tick  <= w_wrap && !cnt_max;
         r_clear <= w_clr;
         r_lap   <= (w_next == SPLIT);
         if (w_latch) begin
            r_hold <= cnt_digits;
         end
         if (w_next == SPLIT) begin
            r_disp <= w_latch ? cnt_digits : r_hold;
         end else begin
            r_disp <= cnt_digits;
         end
      end
   end

   assign tick       = r_tick;
   assign cnt_clear  = r_clear;
   assign disp       = r_disp;
   assign state      = r_state;
   assign lap_active = r_lap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at DIV = 10 (1000 Hz clock, 100 Hz tick).
module tb_stopwatch_ctrl;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_SPLIT = 2'd3;

   logic        clk;
   logic        rst_n;
   logic        start_pulse;
   logic        lap_pulse;
   logic        clr_pulse;
   logic [15:0] cnt_digits;
   logic        cnt_max;
   logic        tick;
   logic        cnt_clear;
   logic [15:0] disp;
   logic [1:0]  state;
   logic        lap_active;

   int n_checks;
   int n_fail;

   stopwatch_ctrl #(
      .IN_CLK_HZ (1000),
      .TICK_HZ   (100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_pulse (start_pulse),
      .lap_pulse   (lap_pulse),
      .clr_pulse   (clr_pulse),
      .cnt_digits  (cnt_digits),
      .cnt_max     (cnt_max),
      .tick        (tick),
      .cnt_clear   (cnt_clear),
      .disp        (disp),
      .state       (state),
      .lap_active  (lap_active)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle key pulses sampled on the next edge.
   task automatic press(input logic s, input logic l, input logic c);
      start_pulse = s;
      lap_pulse   = l;
      clr_pulse   = c;
      @(posedge clk);
      #1;
      start_pulse = 1'b0;
      lap_pulse   = 1'b0;
      clr_pulse   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_pulse = 1'b0;
      lap_pulse = 1'b0;
      clr_pulse = 1'b0;
      cnt_digits = 16'h0000;
      cnt_max = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
      n_checks++;
      if ({tick, cnt_clear, lap_active} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {tick, cnt_clear, lap_active}); end
      n_checks++;
      if (disp !== 16'h0000) begin n_fail++; $display("FAIL reset_disp: got %h expected 0000", disp); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_first_ticks();
      logic exp;
      press(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (state !== S_RUN) begin n_fail++; $display("FAIL start_state: got %0d expected %0d", state, S_RUN); end
      for (int i = 1; i <= 30; i++) begin
         step();
         exp = (i % 10 == 0);
         n_checks++;
         if (tick !== exp) begin n_fail++; $display("FAIL first_tick c=%0d: got %b expected %b", i, tick, exp); end
         n_checks++;
         if (cnt_clear !== 1'b0) begin n_fail++; $display("FAIL run_clear c=%0d: got %b expected 0", i, cnt_clear); end
      end
   endtask

   task automatic test_pause_resume();
      logic exp;
      for (int i = 1; i <= 24; i++) begin
         step();
         exp = (i % 10 == 0);
         n_checks++;
         if (tick !== exp) begin n_fail++; $display("FAIL pre_pause_tick c=%0d: got %b expected %b", i, tick, exp); end
      end
      press(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (state !== S_PAUSE || tick !== 1'b0) begin n_fail++; $display("FAIL pause_enter: got state %0d tick %b expected %0d 0", state, tick, S_PAUSE); end
      for (int i = 1; i <= 40; i++) begin
         step();
         n_checks++;
         if (tick !== 1'b0 || state !== S_PAUSE) begin n_fail++; $display("FAIL pause_hold c=%0d: got tick %b state %0d expected 0 %0d", i, tick, state, S_PAUSE); end
      end
      press(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (state !== S_RUN) begin n_fail++; $display("FAIL resume_state: got %0d expected %0d", state, S_RUN); end
      for (int i = 1; i <= 15; i++) begin
         step();
         exp = (i == 5) || (i == 15);
         n_checks++;
         if (tick !== exp) begin n_fail++; $display("FAIL resume_tick c=%0d: got %b expected %b", i, tick, exp); end
      end
   endtask

   task automatic test_split();
      logic exp;
      cnt_digits = 16'h1234;
      step();
      n_checks++;
      if (disp !== 16'h1234) begin n_fail++; $display("FAIL disp_follow: got %h expected 1234", disp); end
      press(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (state !== S_SPLIT || lap_active !== 1'b1) begin n_fail++; $display("FAIL split_enter: got state %0d lap %b expected %0d 1", state, lap_active, S_SPLIT); end
      cnt_digits = 16'h1240;
      for (int i = 3; i <= 12; i++) begin
         step();
         exp = (i == 10);
         n_checks++;
         if (disp !== 16'h1234) begin n_fail++; $display("FAIL split_hold c=%0d: got %h expected 1234", i, disp); end
         n_checks++;
         if (tick !== exp) begin n_fail++; $display("FAIL split_tick c=%0d: got %b expected %b", i, tick, exp); end
      end
      press(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (state !== S_RUN || lap_active !== 1'b0) begin n_fail++; $display("FAIL split_exit: got state %0d lap %b expected %0d 0", state, lap_active, S_RUN); end
      n_checks++;
      if (disp !== 16'h1240) begin n_fail++; $display("FAIL split_release: got %h expected 1240", disp); end
   endtask

   task automatic test_clear();
      logic exp;
      press(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (state !== S_RUN || cnt_clear !== 1'b0) begin n_fail++; $display("FAIL clr_in_run: got state %0d clr %b expected %0d 0", state, cnt_clear, S_RUN); end
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (state !== S_IDLE || cnt_clear !== 1'b1 || tick !== 1'b0) begin n_fail++; $display("FAIL clr_pause: got state %0d clr %b tick %b expected %0d 1 0", state, cnt_clear, tick, S_IDLE); end
      step();
      n_checks++;
      if (cnt_clear !== 1'b0 || state !== S_IDLE) begin n_fail++; $display("FAIL clr_width: got clr %b state %0d expected 0 %0d", cnt_clear, state, S_IDLE); end
      press(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (state !== S_IDLE || cnt_clear !== 1'b1) begin n_fail++; $display("FAIL clr_idle: got state %0d clr %b expected %0d 1", state, cnt_clear, S_IDLE); end
      press(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         exp = (i == 10);
         n_checks++;
         if (cnt_clear !== (i == 1 ? 1'b0 : 1'b0)) begin n_fail++; $display("FAIL clr_after c=%0d: got %b expected 0", i, cnt_clear); end
         step();
         n_checks++;
         if (tick !== exp) begin n_fail++; $display("FAIL restart_tick c=%0d: got %b expected %b", i, tick, exp); end
      end
   endtask

   task automatic test_priority();
      cnt_digits = 16'h0555;
      press(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (state !== S_PAUSE || lap_active !== 1'b0) begin n_fail++; $display("FAIL start_lap_run: got state %0d lap %b expected %0d 0", state, lap_active, S_PAUSE); end
      cnt_digits = 16'h0600;
      step();
      n_checks++;
      if (disp !== 16'h0600) begin n_fail++; $display("FAIL no_latch: got %h expected 0600", disp); end
      press(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (state !== S_IDLE || cnt_clear !== 1'b1 || tick !== 1'b0) begin n_fail++; $display("FAIL all_keys_pause: got state %0d clr %b tick %b expected %0d 1 0", state, cnt_clear, tick, S_IDLE); end
   endtask

   task automatic test_saturation();
      logic exp;
      press(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) step();
      cnt_digits = 16'h5958;
      press(1'b0, 1'b1, 1'b0);
      cnt_digits = 16'h5959;
      cnt_max = 1'b1;
      for (int i = 5; i <= 9; i++) begin
         step();
         n_checks++;
         if (state !== S_SPLIT || tick !== 1'b0 || disp !== 16'h5958) begin n_fail++; $display("FAIL sat_pre c=%0d: got state %0d tick %b disp %h expected %0d 0 5958", i, state, tick, disp, S_SPLIT); end
      end
      step();
      n_checks++;
      if (tick !== 1'b0) begin n_fail++; $display("FAIL sat_tick: got %b expected 0", tick); end
      n_checks++;
      if (state !== S_PAUSE || lap_active !== 1'b0 || disp !== 16'h5959) begin n_fail++; $display("FAIL sat_stop: got state %0d lap %b disp %h expected %0d 0 5959", state, lap_active, disp, S_PAUSE); end
      for (int i = 1; i <= 12; i++) begin
         step();
         n_checks++;
         if (tick !== 1'b0 || state !== S_PAUSE) begin n_fail++; $display("FAIL sat_hold c=%0d: got tick %b state %0d expected 0 %0d", i, tick, state, S_PAUSE); end
      end
      cnt_max = 1'b0;
      press(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step();
         exp = (i == 10);
         n_checks++;
         if (tick !== exp) begin n_fail++; $display("FAIL sat_resume c=%0d: got %b expected %b", i, tick, exp); end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 9; i++) step();
      press(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (tick !== 1'b1 || state !== S_PAUSE) begin n_fail++; $display("FAIL start_with_tick: got tick %b state %0d expected 1 %0d", tick, state, S_PAUSE); end
      step();
      n_checks++;
      if (tick !== 1'b0) begin n_fail++; $display("FAIL tick_after_pause: got %b expected 0", tick); end
   endtask

   task automatic test_async_reset();
      press(1'b1, 1'b0, 1'b0);
      cnt_digits = 16'h0101;
      press(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (state !== S_SPLIT || disp !== 16'h0101) begin n_fail++; $display("FAIL pre_reset_split: got state %0d disp %h expected %0d 0101", state, disp, S_SPLIT); end
      cnt_digits = 16'h0202;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (state !== S_IDLE || disp !== 16'h0000 || lap_active !== 1'b0) begin n_fail++; $display("FAIL async_reset: got state %0d disp %h lap %b expected %0d 0000 0", state, disp, lap_active, S_IDLE); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step();
         n_checks++;
         if (tick !== 1'b0 || cnt_clear !== 1'b0 || state !== S_IDLE) begin n_fail++; $display("FAIL post_reset c=%0d: got tick %b clr %b state %0d expected 0 0 %0d", i, tick, cnt_clear, state, S_IDLE); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      test_reset();
      test_first_ticks();
      test_pause_resume();
      test_split();
      test_clear();
      test_priority();
      test_saturation();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
